nn_vector_feeder: RTL and testbench

- Initiator-side sequencer for the parallel INT8 MAC accelerator datapath.
- Accepts a serial valid/ready stream of (activation, weight) pairs and assembles N-element operand vectors.
- For each complete vector: latches bias/scale, pulses start to the accelerator, waits for done, captures the saturated INT8 result and presents it on a valid/ready result port.
- Keeps sparsity and throughput statistics and a sticky timeout error.

---
 rtl/nn_vector_feeder.sv | 213 +++++++++++++++++++++
 tb/tb_nn_vector_feeder.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/nn_vector_feeder.sv
// nn_vector_feeder: collects a serial stream of (activation, weight) pairs
// into an N-lane operand vector, starts the INT8 MAC accelerator, waits for
// its result (or a timeout) and presents the result on a valid/ready port.
// Also keeps saturating sparsity/throughput statistics and a sticky timeout flag.
module nn_vector_feeder #(
    parameter int N       = 4,
    parameter int TIMEOUT = 15,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               s_valid,
    output logic               s_ready,
    input  logic [7:0]         s_act,
    input  logic [7:0]         s_wt,
    input  logic [31:0]        cfg_bias,
    input  logic [3:0]         cfg_scale,
    output logic               acc_start,
    output logic [8*N-1:0]     acc_act,
    output logic [8*N-1:0]     acc_wt,
    output logic [31:0]        acc_bias,
    output logic [3:0]         acc_scale,
    input  logic               acc_done,
    input  logic [7:0]         acc_out,
    output logic               m_valid,
    input  logic               m_ready,
    output logic [7:0]         m_data,
    output logic               m_err,
    output logic               err_timeout,
    output logic [CNT_W-1:0]   stat_vectors,
    output logic [CNT_W-1:0]   stat_zero_acts
);

    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam int TMR_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        ST_FILL  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_HOLD  = 2'd3
    } state_t;

    state_t             state_r;
    state_t             state_s;
    logic [IDX_W-1:0]   idx_r;
    logic [TMR_W-1:0]   timer_r;
    logic [8*N-1:0]     act_r;
    logic [8*N-1:0]     wt_r;
    logic [31:0]        bias_r;
    logic [3:0]         scale_r;
    logic [7:0]         m_data_r;
    logic               m_err_r;
    logic               err_timeout_r;
    logic [CNT_W-1:0]   stat_vectors_r;
    logic [CNT_W-1:0]   stat_zero_acts_r;

    logic               s_ready_s;
    logic               acc_start_s;
    logic               m_valid_s;
    logic               hs_s;
    logic               last_s;
    logic               expire_s;

    // Saturating increment: counters stick at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    assign hs_s     = s_valid & s_ready_s;
    assign last_s   = (idx_r == IDX_W'(N - 1));
    assign expire_s = (timer_r == TMR_W'(TIMEOUT - 1));

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_FILL;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic; acc_done wins over timer expiry in WAIT.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_FILL: begin
                if (hs_s && last_s) begin
                    state_s = ST_ISSUE;
                end else begin
                    state_s = ST_FILL;
                end
            end
            ST_ISSUE: begin
                state_s = ST_WAIT;
            end
            ST_WAIT: begin
                if (acc_done || expire_s) begin
                    state_s = ST_HOLD;
                end else begin
                    state_s = ST_WAIT;
                end
            end
            ST_HOLD: begin
                if (m_ready) begin
                    state_s = ST_FILL;
                end else begin
                    state_s = ST_HOLD;
                end
            end
            default: begin
                state_s = ST_FILL;
            end
        endcase
    end

    // Handshake/strobe outputs decoded straight from the state register.
    always_comb begin
        s_ready_s   = 1'b0;
        acc_start_s = 1'b0;
        m_valid_s   = 1'b0;
        case (state_r)
            ST_FILL:  s_ready_s   = 1'b1;
            ST_ISSUE: acc_start_s = 1'b1;
            ST_WAIT:  m_valid_s   = 1'b0;
            ST_HOLD:  m_valid_s   = 1'b1;
            default:  s_ready_s   = 1'b0;
        endcase
    end

    // Lane index and operand capture; operands move only on FILL handshakes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_r   <= '0;
            act_r   <= '0;
            wt_r    <= '0;
            bias_r  <= 32'd0;
            scale_r <= 4'd0;
        end else if (hs_s) begin
            for (int i = 0; i < N; i++) begin
                if (idx_r == IDX_W'(i)) begin
                    act_r[8*i +: 8] <= s_act;
                    wt_r[8*i +: 8]  <= s_wt;
                end
            end
            if (last_s) begin
                idx_r   <= '0;
                bias_r  <= cfg_bias;
                scale_r <= cfg_scale;
            end else begin
                idx_r <= idx_r + IDX_W'(1);
            end
        end
    end

    // WAIT timer: cleared while issuing, counts every WAIT cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer_r <= '0;
        end else if (state_r == ST_ISSUE) begin
            timer_r <= '0;
        end else if (state_r == ST_WAIT) begin
            timer_r <= timer_r + TMR_W'(1);
        end
    end

    // Result capture and sticky timeout flag, only ever updated from WAIT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_data_r      <= 8'd0;
            m_err_r       <= 1'b0;
            err_timeout_r <= 1'b0;
        end else if (state_r == ST_WAIT) begin
            if (acc_done) begin
                m_data_r <= acc_out;
                m_err_r  <= 1'b0;
            end else if (expire_s) begin
                m_data_r      <= 8'd0;
                m_err_r       <= 1'b1;
                err_timeout_r <= 1'b1;
            end
        end
    end

    // Saturating statistics: zero activations accepted, vectors completed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_vectors_r   <= '0;
            stat_zero_acts_r <= '0;
        end else begin
            if (hs_s && (s_act == 8'd0)) begin
                stat_zero_acts_r <= sat_inc(stat_zero_acts_r);
            end
            if ((state_r == ST_WAIT) && acc_done) begin
                stat_vectors_r <= sat_inc(stat_vectors_r);
            end
        end
    end

    assign s_ready        = s_ready_s;
    assign acc_start      = acc_start_s;
    assign m_valid        = m_valid_s;
    assign acc_act        = act_r;
    assign acc_wt         = wt_r;
    assign acc_bias       = bias_r;
    assign acc_scale      = scale_r;
    assign m_data         = m_data_r;
    assign m_err          = m_err_r;
    assign err_timeout    = err_timeout_r;
    assign stat_vectors   = stat_vectors_r;
    assign stat_zero_acts = stat_zero_acts_r;

endmodule

// File: tb/tb_nn_vector_feeder.sv
// Directed testbench for nn_vector_feeder (N=4, TIMEOUT=15, CNT_W=16).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_nn_vector_feeder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [7:0]  s_act = 8'd0;
    logic [7:0]  s_wt = 8'd0;
    logic [31:0] cfg_bias = 32'd0;
    logic [3:0]  cfg_scale = 4'd0;
    logic        acc_start;
    logic [31:0] acc_act;
    logic [31:0] acc_wt;
    logic [31:0] acc_bias;
    logic [3:0]  acc_scale;
    logic        acc_done;
    logic [7:0]  acc_out;
    logic        m_valid;
    logic        m_ready = 1'b0;
    logic [7:0]  m_data;
    logic        m_err;
    logic        err_timeout;
    logic [15:0] stat_vectors;
    logic [15:0] stat_zero_acts;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int hs_cyc  = 0;
    int start_cnt = 0;
    int lat;
    int starts0;
    bit stable;
    logic [7:0] held;

    // Accelerator model: done pulse two cycles after start, or never when disabled.
    bit         model_en = 1'b1;
    logic [7:0] model_val = 8'd0;
    logic [7:0] model_out = 8'd0;
    logic       model_done = 1'b0;
    logic       stray_done = 1'b0;
    int         cd = 0;

    assign acc_done = model_done | stray_done;
    assign acc_out  = stray_done ? 8'd55 : model_out;

    nn_vector_feeder #(.N(4), .TIMEOUT(15), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_valid(s_valid), .s_ready(s_ready), .s_act(s_act), .s_wt(s_wt),
        .cfg_bias(cfg_bias), .cfg_scale(cfg_scale),
        .acc_start(acc_start), .acc_act(acc_act), .acc_wt(acc_wt),
        .acc_bias(acc_bias), .acc_scale(acc_scale),
        .acc_done(acc_done), .acc_out(acc_out),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_err(m_err),
        .err_timeout(err_timeout),
        .stat_vectors(stat_vectors), .stat_zero_acts(stat_zero_acts)
    );

    always #5 clk = ~clk;

    // Cycle counter and acc_start pulse counter.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (acc_start) start_cnt <= start_cnt + 1;
    end

    // Accelerator response timing.
    always @(negedge clk) begin
        model_done = 1'b0;
        if (cd != 0) begin
            cd = cd - 1;
            if (cd == 0) begin
                model_done = 1'b1;
                model_out  = model_val;
            end
        end
        if (acc_start && model_en) cd = 2;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Offer one pair at a falling edge and hold it until accepted.
    task automatic send_pair(input logic [7:0] a, input logic [7:0] w, input bit bubble);
        bit done;
        done = 1'b0;
        s_valid = 1'b1;
        s_act = a;
        s_wt = w;
        for (int k = 0; k < 60 && !done; k++) begin
            if (s_ready) begin
                hs_cyc = cyc;
                done = 1'b1;
            end
            @(negedge clk);
        end
        if (!done) check("send_timeout", 64'd0, 64'd1);
        s_valid = 1'b0;
        if (bubble) @(negedge clk);
    endtask

    // Four-pair vector; bias/scale change just before the final pair.
    task automatic send_vec(input logic [31:0] acts, input logic [31:0] wts,
                            input logic [31:0] bias, input logic [3:0] scale, input bit bubble);
        for (int i = 0; i < 4; i++) begin
            if (i == 3) begin
                cfg_bias = bias;
                cfg_scale = scale;
            end
            send_pair(acts[8*i +: 8], wts[8*i +: 8], bubble && (i < 3));
        end
    endtask

    // Wait (bounded) for m_valid; latency is counted from the last handshake.
    task automatic wait_valid(output int l);
        bit found;
        found = 1'b0;
        l = -1;
        for (int k = 0; k < 40 && !found; k++) begin
            if (m_valid) begin
                l = cyc - hs_cyc;
                found = 1'b1;
            end else begin
                @(negedge clk);
            end
        end
        if (!found) check("valid_timeout", 64'd0, 64'd1);
    endtask

    task automatic drain();
        m_ready = 1'b1;
        @(negedge clk);
        m_ready = 1'b0;
    endtask

    initial begin
        // Reset state
        @(negedge clk);
        check("rst_s_ready", s_ready, 1);
        check("rst_outputs", {acc_start, m_valid, m_err, err_timeout, m_data}, 0);
        check("rst_operands", {acc_act, acc_wt, acc_bias, acc_scale}, 0);
        check("rst_stats", {stat_vectors, stat_zero_acts}, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic vector
        model_val = 8'd10;
        send_vec(32'h04030201, 32'h01010101, 32'd0, 4'd0, 1'b0);
        check("basic_start", acc_start, 1);
        wait_valid(lat);
        check("basic_latency", lat, 4);
        check("basic_act", acc_act, 32'h04030201);
        check("basic_wt", acc_wt, 32'h01010101);
        check("basic_data", {m_err, m_data}, {1'b0, 8'd10});
        check("basic_vectors", stat_vectors, 1);
        check("basic_starts", start_cnt, 1);
        drain();
        check("basic_refill", {s_ready, m_valid}, 2'b10);

        // Sparsity and saturated result
        model_val = 8'd127;
        send_vec(32'hFD000500, 32'h64646464, 32'd0, 4'd0, 1'b0);
        wait_valid(lat);
        check("sparse_zero_acts", stat_zero_acts, 2);
        check("sparse_act", acc_act, 32'hFD000500);
        check("sparse_data", m_data, 8'd127);
        drain();

        // Backpressure
        model_val = 8'hEC;
        send_vec(32'h07070707, 32'h01010101, 32'd0, 4'd0, 1'b0);
        wait_valid(lat);
        starts0 = start_cnt;
        held = m_data;
        stable = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (m_data !== held || s_ready !== 1'b0 || m_valid !== 1'b1) stable = 1'b0;
        end
        check("bp_stable", stable, 1);
        check("bp_data", held, 8'hEC);
        check("bp_no_restart", start_cnt, starts0);
        drain();
        check("bp_refill", s_ready, 1);
        check("bp_vectors", stat_vectors, 3);

        // Timeout: no acc_done, 15 WAIT cycles then error result
        model_en = 1'b0;
        send_vec(32'h01020304, 32'h01010101, 32'd0, 4'd0, 1'b0);
        wait_valid(lat);
        check("to_latency", lat, 17);
        check("to_result", {m_err, err_timeout, m_data}, {1'b1, 1'b1, 8'd0});
        check("to_vectors", stat_vectors, 3);
        stray_done = 1'b1;
        @(negedge clk);
        stray_done = 1'b0;
        @(negedge clk);
        check("stray_ignored", {m_valid, m_err, m_data}, {1'b1, 1'b1, 8'd0});
        check("stray_vectors", stat_vectors, 3);
        drain();
        model_en = 1'b1;
        check("to_sticky", err_timeout, 1);

        // Stream bubbles, bias changed before final pair
        cfg_bias = 32'd100;
        model_val = 8'd1;
        send_vec(32'h14131211, 32'h24232221, 32'hFFFFFFCE, 4'd3, 1'b1);
        wait_valid(lat);
        check("bub_act", acc_act, 32'h14131211);
        check("bub_wt", acc_wt, 32'h24232221);
        check("bub_bias", acc_bias, 32'hFFFFFFCE);
        check("bub_scale", acc_scale, 4'd3);
        check("bub_zero_acts", stat_zero_acts, 2);
        drain();

        // Reset during WAIT; late done must not produce a result
        model_val = 8'd33;
        send_vec(32'h05060708, 32'h02020202, 32'd0, 4'd0, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_rst_ready", s_ready, 1);
        check("mid_rst_outputs", {acc_start, m_valid, m_err, err_timeout, m_data}, 0);
        check("mid_rst_operands", {acc_act, acc_wt, acc_bias, acc_scale}, 0);
        check("mid_rst_stats", {stat_vectors, stat_zero_acts}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        stable = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (m_valid !== 1'b0 || s_ready !== 1'b1) stable = 1'b0;
        end
        check("late_done_ignored", stable, 1);
        model_val = 8'd42;
        send_vec(32'h01010101, 32'h03030303, 32'd7, 4'd1, 1'b0);
        wait_valid(lat);
        check("post_rst_latency", lat, 4);
        check("post_rst_data", {m_err, m_data}, {1'b0, 8'd42});
        check("post_rst_vectors", stat_vectors, 1);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
